// File: rtl/rr_arb8_idx.sv
// Round-robin arbiter for 8 requesters with binary-index grant output,
// optional hold-time limit and a one-cycle timeout pulse.
module rr_arb8_idx #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    localparam logic             HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
    logic [IDX_W-1:0]   gnt_idx_n;
    logic               gnt_valid_n;
    logic               timeout_n;

    logic               win_found_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic [IDX_W-1:0]   cand_c;
    logic               hold_hit_c;
    logic               grant_end_c;

    // First set request bit searching upward from ptr, wrapping modulo 8.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = '0;
        for (int k = 0; k < N; k++) begin
            cand_c = IDX_W'(ptr + IDX_W'(k));
            if (!win_found_c && req[cand_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
    end

    assign hold_hit_c  = HOLD_EN && (hold_cnt == HOLD_LAST);
    assign grant_end_c = done || !req[gnt_idx] || hold_hit_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        hold_cnt_n  = hold_cnt;
        gnt_idx_n   = gnt_idx;
        gnt_valid_n = gnt_valid;
        timeout_n   = 1'b0;

        unique case (state)
            IDLE: begin
                gnt_valid_n = 1'b0;
                if (win_found_c) begin
                    gnt_idx_n   = win_idx_c;
                    gnt_valid_n = 1'b1;
                    hold_cnt_n  = '0;
                    state_n     = GRANT;
                end
            end
            GRANT: begin
                if (grant_end_c) begin
                    gnt_valid_n = 1'b0;
                    ptr_n       = IDX_W'(gnt_idx + IDX_W'(1));
                    state_n     = IDLE;
                    // Only the hold limit, with no done and no withdrawal, flags timeout.
                    timeout_n   = !done && req[gnt_idx];
                end else begin
                    hold_cnt_n = CNT_W'(hold_cnt + CNT_W'(1));
                end
            end
            default: begin
                state_n     = IDLE;
                gnt_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_cnt_n;
            gnt_idx   <= gnt_idx_n;
            gnt_valid <= gnt_valid_n;
            timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_arb8_idx.sv
// Bench for rr_arb8_idx: directed scenarios plus random traffic against a
// cycle-level reference model of the arbitration rules.
module tb_rr_arb8_idx;

    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned CNT_W    = 5;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int errors;
    int checks;

    // Reference model state
    int m_valid;
    int m_idx;
    int m_ptr;
    int m_held;
    int m_to;

    rr_arb8_idx #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 0;
    endtask

    // Apply one clock edge of the arbitration rules to the model.
    task automatic m_edge(input logic [7:0] r, input logic d);
        int pick;
        if (m_valid == 0) begin
            m_to = 0;
            pick = -1;
            for (int k = 0; k < 8; k++) begin
                if (pick < 0 && r[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
            end
            if (pick >= 0) begin
                m_idx   = pick;
                m_valid = 1;
                m_held  = 1;
            end
        end else begin
            if (d || !r[m_idx] || (MAX_HOLD != 0 && m_held == int'(MAX_HOLD))) begin
                m_to    = (!d && r[m_idx]) ? 1 : 0;
                m_valid = 0;
                m_ptr   = (m_idx + 1) % 8;
            end else begin
                m_held++;
                m_to = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, int'(gnt_valid), m_valid);
        check({tag, "_idx"}, int'(gnt_idx), m_idx);
        check({tag, "_timeout"}, int'(timeout), m_to);
    endtask

    // Called at a negedge; drives inputs, takes one edge, checks, returns at the next negedge.
    task automatic cycle(input string tag, input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        m_edge(r, d);
        #1;
        check_model(tag);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        check("rst_valid", int'(gnt_valid), 0);
        check("rst_idx", int'(gnt_idx), 0);
        check("rst_timeout", int'(timeout), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        logic       d;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        req    = '0;
        done   = 1'b0;
        m_reset();

        #7;
        check("por_valid", int'(gnt_valid), 0);
        check("por_idx", int'(gnt_idx), 0);
        check("por_timeout", int'(timeout), 0);
        @(negedge clk);
        rst = 1'b0;

        // T1: asynchronous reset in the middle of a grant
        cycle("t1_grant", 8'h08, 1'b0);
        check("t1_idx3", int'(gnt_idx), 3);
        rst = 1'b1;
        #1;
        check("t1_async_valid", int'(gnt_valid), 0);
        check("t1_async_idx", int'(gnt_idx), 0);
        check("t1_async_timeout", int'(timeout), 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle("t1_after", 8'h01, 1'b0);
        check("t1_idx0", int'(gnt_idx), 0);
        cycle("t1_end", 8'h01, 1'b1);

        // T2: single requester
        reset_dut();
        cycle("t2_grant", 8'h10, 1'b0);
        check("t2_idx4", int'(gnt_idx), 4);
        cycle("t2_done", 8'h10, 1'b1);
        check("t2_ptr", int'(dut.ptr), 5);
        cycle("t2_idle", 8'h00, 1'b0);

        // T3: all requesting, done each grant -> 0..7,0 with one idle cycle between
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            cycle("t3_grant", 8'hFF, 1'b0);
            check("t3_seq", int'(gnt_idx), i % 8);
            check("t3_live", int'(gnt_valid), 1);
            cycle("t3_gap", 8'hFF, 1'b1);
            check("t3_gapv", int'(gnt_valid), 0);
        end

        // T4: wrap-around search
        cycle("t4_g5", 8'h20, 1'b0);
        check("t4_idx5", int'(gnt_idx), 5);
        cycle("t4_end", 8'h20, 1'b1);
        cycle("t4_wrap", 8'h21, 1'b0);
        check("t4_idx0", int'(gnt_idx), 0);
        cycle("t4_end2", 8'h21, 1'b1);

        // T5: hold limit timeout
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            cycle("t5_hold", 8'h02, 1'b0);
            check("t5_hold_valid", int'(gnt_valid), 1);
        end
        cycle("t5_to", 8'h02, 1'b0);
        check("t5_to_pulse", int'(timeout), 1);
        check("t5_to_valid", int'(gnt_valid), 0);
        cycle("t5_regrant", 8'h02, 1'b0);
        check("t5_regrant_idx", int'(gnt_idx), 1);
        check("t5_to_cleared", int'(timeout), 0);

        // T6: withdrawal ends grant without timeout; done beats timeout
        cycle("t6_withdraw", 8'h00, 1'b0);
        check("t6_wd_to", int'(timeout), 0);
        cycle("t6_idle", 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) cycle("t6_hold", 8'h04, 1'b0);
        cycle("t6_collide", 8'h04, 1'b1);
        check("t6_col_to", int'(timeout), 0);
        check("t6_col_valid", int'(gnt_valid), 0);
        cycle("t6_idle2", 8'h00, 1'b0);

        // Random traffic
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            else if ($urandom_range(0, 3) == 0) r = 8'(1 << $urandom_range(0, 7));
            d = ($urandom_range(0, 5) == 0);
            cycle("rnd", r, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
